// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter using reverse double-dabble,
// one shift per clock, with start/busy/done handshake and bad-digit detection.
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BIN_W-1:0]   bin_reg;
  logic [CNT_W-1:0]   cnt;
  logic [BCD_W-1:0]   bcd_shift;
  logic [BCD_W-1:0]   bcd_next;
  logic [BIN_W-1:0]   bin_shift;
  logic               bad_in;
  logic               last_iter;

  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Undo the add-3 of forward double-dabble: any digit that picked up a
  // shifted-in weight of 8 really represents 5 in the lower decade.
  function automatic logic [BCD_W-1:0] dabble_fix(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd8) r[4*i +: 4] = v[4*i +: 4] - 4'd3;
    end
    return r;
  endfunction

  assign bad_in    = has_bad_digit(bcd_in);
  assign last_iter = (cnt == CNT_W'(BIN_W - 1));
  assign bcd_shift = {1'b0, bcd_reg[BCD_W-1:1]};
  assign bin_shift = {bcd_reg[0], bin_reg[BIN_W-1:1]};
  assign bcd_next  = dabble_fix(bcd_shift);

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = bad_in ? DONE : SHIFT;
      SHIFT:   if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Iteration stage: load on acceptance, shift/correct while in SHIFT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (bad_in) begin
              err     <= 1'b1;
              bin_out <= '0;
            end else begin
              bcd_reg <= bcd_in;
              bin_reg <= '0;
              cnt     <= '0;
              err     <= 1'b0;
            end
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_next;
          bin_reg <= bin_shift;
          cnt     <= cnt + CNT_W'(1);
          if (last_iter) bin_out <= bin_shift;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Randomized self-checking bench for bcd_to_bin_seq: default 4-digit instance
// plus a 2-digit instance that is swept exhaustively.
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int S_DIG  = 2;
  localparam int S_BW   = 7;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              start;
  logic [15:0]       bcd_in;
  logic              busy, done, err;
  logic [BIN_W-1:0]  bin_out;

  logic              s_start;
  logic [7:0]        s_bcd;
  logic              s_busy, s_done, s_err;
  logic [S_BW-1:0]   s_bin;

  int checks = 0;
  int errors = 0;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .bin_out(bin_out), .err(err)
  );

  bcd_to_bin_seq #(.DIGITS(S_DIG), .BIN_W(S_BW)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .bcd_in(s_bcd),
    .busy(s_busy), .done(s_done), .bin_out(s_bin), .err(s_err)
  );

  // Decimal value of a packed BCD word, and whether any nibble is not a digit
  function automatic int ref_val(input logic [31:0] v, input int nd);
    int sum, p;
    sum = 0; p = 1;
    for (int i = 0; i < nd; i++) begin
      sum += int'(v[4*i +: 4]) * p;
      p   *= 10;
    end
    return sum;
  endfunction

  function automatic bit ref_bad(input logic [31:0] v, input int nd);
    bit b;
    b = 0;
    for (int i = 0; i < nd; i++) if (v[4*i +: 4] > 4'd9) b = 1;
    return b;
  endfunction

  // After a successful conversion every BCD digit must have been consumed
  always @(negedge clk) begin
    if (rst_n && done && !err) begin
      checks++;
      if (dut.bcd_reg !== '0) begin
        errors++;
        $display("FAIL bcd_reg_empty got %h want 0", dut.bcd_reg);
      end
    end
    if (rst_n && s_done && !s_err) begin
      checks++;
      if (u_small.bcd_reg !== '0) begin
        errors++;
        $display("FAIL small_bcd_reg_empty got %h want 0", u_small.bcd_reg);
      end
    end
  end

  task automatic do_req(input logic [15:0] v, output int lat, output int nbusy,
                        output bit held, output logic err_at1);
    logic [BIN_W-1:0] prev;
    @(negedge clk);
    start = 1'b1; bcd_in = v; prev = bin_out;
    @(posedge clk);
    lat = 0; nbusy = 0; held = 1; err_at1 = 1'bx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (lat == 1) err_at1 = err;
      if (busy) nbusy++;
      if (done) break;
      if (bin_out !== prev) held = 0;
    end
  endtask

  task automatic do_req_s(input logic [7:0] v, output int lat);
    @(negedge clk);
    s_start = 1'b1; s_bcd = v;
    @(posedge clk);
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      s_start = 1'b0;
      lat++;
      if (s_done) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; bcd_in = '0; s_start = 1'b0; s_bcd = '0;
    #12;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (bin_out !== '0)  begin errors++; $display("FAIL reset_bin got %0d want 0", bin_out); end
    checks++; if (err !== 1'b0)    begin errors++; $display("FAIL reset_err got %b want 0", err); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_max();
    int lat, nb; bit held; logic e1;
    do_req(16'h9999, lat, nb, held, e1);
    checks++; if (lat != BIN_W + 1) begin errors++; $display("FAIL max_latency got %0d want %0d", lat, BIN_W + 1); end
    checks++; if (nb != BIN_W)      begin errors++; $display("FAIL max_busy_cycles got %0d want %0d", nb, BIN_W); end
    checks++; if (bin_out !== 14'd9999) begin errors++; $display("FAIL max_value got %0d want 9999", bin_out); end
    checks++; if (err !== 1'b0)     begin errors++; $display("FAIL max_err got %b want 0", err); end
  endtask

  task automatic test_hold();
    int lat, nb; bit held; logic e1;
    do_req(16'h1234, lat, nb, held, e1);
    checks++; if (bin_out !== 14'd1234) begin errors++; $display("FAIL hold_first got %0d want 1234", bin_out); end
    do_req(16'h0000, lat, nb, held, e1);
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL hold_during_shift got %b want 1", held); end
    checks++; if (bin_out !== '0) begin errors++; $display("FAIL hold_zero got %0d want 0", bin_out); end
  endtask

  task automatic test_invalid();
    int lat, nb; bit held; logic e1;
    do_req(16'h12A4, lat, nb, held, e1);
    checks++; if (lat != 1)       begin errors++; $display("FAIL inv_latency got %0d want 1", lat); end
    checks++; if (nb != 0)        begin errors++; $display("FAIL inv_busy got %0d want 0", nb); end
    checks++; if (err !== 1'b1)   begin errors++; $display("FAIL inv_err got %b want 1", err); end
    checks++; if (bin_out !== '0) begin errors++; $display("FAIL inv_bin got %0d want 0", bin_out); end
    do_req(16'h0042, lat, nb, held, e1);
    checks++; if (e1 !== 1'b0)    begin errors++; $display("FAIL inv_err_clear got %b want 0", e1); end
    checks++; if (bin_out !== 14'd42) begin errors++; $display("FAIL inv_followup got %0d want 42", bin_out); end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk); start = 1'b1; bcd_in = 16'h0500;
    @(posedge clk);
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lat++;
      if (done) break;
      bcd_in = 16'h9999;
      start  = (lat == 5);
    end
    checks++; if (lat != BIN_W + 1) begin errors++; $display("FAIL ign_latency got %0d want %0d", lat, BIN_W + 1); end
    checks++; if (bin_out !== 14'd500) begin errors++; $display("FAIL ign_value got %0d want 500", bin_out); end
    start = 1'b1; bcd_in = 16'h9999;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ign_done_start got busy=%b done=%b want 0 0", busy, done); end
    start = 1'b1; bcd_in = 16'h0077;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_next_accept got %b want 1", busy); end
    for (int k = 0; k < 40; k++) begin
      if (done) break;
      @(negedge clk);
    end
    checks++; if (bin_out !== 14'd77 || done !== 1'b1) begin errors++; $display("FAIL ign_next_value got %0d done=%b want 77", bin_out, done); end
  endtask

  task automatic test_reset_mid();
    int lat, nb; bit held, seen; logic e1;
    @(negedge clk); start = 1'b1; bcd_in = 16'h8765;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || bin_out !== '0 || err !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs got busy=%b done=%b bin=%0d err=%b want all 0", busy, done, bin_out, err);
    end
    seen = 0;
    repeat (3) begin @(negedge clk); if (done) seen = 1; end
    rst_n = 1'b1;
    repeat (BIN_W + 2) begin @(negedge clk); if (done) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL rstmid_no_done got 1 want 0"); end
    do_req(16'h0001, lat, nb, held, e1);
    checks++; if (lat != BIN_W + 1 || bin_out !== 14'd1) begin
      errors++; $display("FAIL rstmid_after got lat=%0d bin=%0d want %0d 1", lat, bin_out, BIN_W + 1);
    end
  endtask

  task automatic test_sweep();
    int lat, nb, exp_v, exp_l; bit held, bad; logic e1;
    logic [7:0]  sv;
    logic [15:0] v;
    for (int d = 0; d < 100; d++) begin
      sv = {4'(d / 10), 4'(d % 10)};
      do_req_s(sv, lat);
      checks++;
      if (s_bin !== S_BW'(d) || s_err !== 1'b0 || lat != S_BW + 1) begin
        errors++; $display("FAIL small_sweep in=%h got %0d err=%b lat=%0d want %0d", sv, s_bin, s_err, lat, d);
      end
    end
    for (int p = 0; p < S_DIG; p++) begin
      for (int n = 0; n < 6; n++) begin
        sv = 8'($urandom_range(0, 255));
        sv[4*p +: 4] = 4'($urandom_range(10, 15));
        do_req_s(sv, lat);
        checks++;
        if (s_bin !== '0 || s_err !== 1'b1 || lat != 1) begin
          errors++; $display("FAIL small_invalid in=%h got %0d err=%b lat=%0d want 0 1 1", sv, s_bin, s_err, lat);
        end
      end
    end
    for (int n = 0; n < 300 + 4 * DIGITS * 8; n++) begin
      for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
      if (n >= 300) v[4*((n - 300) % DIGITS) +: 4] = 4'($urandom_range(10, 15));
      bad   = ref_bad({16'h0, v}, DIGITS);
      exp_v = bad ? 0 : ref_val({16'h0, v}, DIGITS);
      exp_l = bad ? 1 : BIN_W + 1;
      do_req(v, lat, nb, held, e1);
      checks++;
      if (bin_out !== BIN_W'(exp_v) || err !== bad || lat != exp_l) begin
        errors++; $display("FAIL rand_conv in=%h got %0d err=%b lat=%0d want %0d err=%b lat=%0d",
                           v, bin_out, err, lat, exp_v, bad, exp_l);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, nb, t0, t1; bit held; logic e1;
    do_req(16'h0007, lat, nb, held, e1);
    t0 = $time;
    do_req(16'h0008, lat, nb, held, e1);
    t1 = $time;
    checks++; if ((t1 - t0) / 10 != BIN_W + 2 || bin_out !== 14'd8) begin
      errors++; $display("FAIL b2b_period got %0d cycles bin=%0d want %0d 8", (t1 - t0) / 10, bin_out, BIN_W + 2);
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_hold();
    test_invalid();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
